noc_output_port_arbiter: RTL and testbench

- Synchronous round-robin arbiter sharing one router output port among N input ports.
- Each input port presents a flit stream that has already been routed to this output by the position-check logic.
- Grants whole packets: the lock is held from the first flit to the flit marked last, so flits of different packets never interleave on the output.
- Sits between the per-input route decode and the output link in each NoC router.

---
 rtl/noc_output_port_arbiter_pkg.sv | 36 +++
 rtl/noc_output_port_arbiter_if.sv | 47 ++++
 rtl/noc_output_port_arbiter_rr_pick.sv | 45 ++++
 rtl/noc_output_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_noc_output_port_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/noc_output_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : noc_arb_pkg
// Description : Shared types, default sizes and helpers for the NoC router
//               output-port arbiter.
// Contents    : arb_state_t    - arbiter FSM state (IDLE / LOCKED)
//               N_DEF, W_DEF   - default port count and flit width
//               onehot_to_idx  - one-hot (up to 8 bits) to binary index
// Revision    : 1.0 - initial release
// ============================================================================
package noc_arb_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Converts a one-hot vector of up to 8 ports into its bit position.
    // OR-accumulation keeps the result well defined for the all-zero vector
    // (returns 0), which callers only use when a grant is actually held.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_output_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : noc_output_port_arbiter_if
// Description : Bundles the N input flit streams, the single output link and
//               the arbiter status signals of one router output port.
// Signals     : in_valid/in_data/in_last  - per-port flit streams (port i at
//                                            in_data[i*W +: W])
//               in_ready                  - per-port accept (arbiter driven)
//               out_valid/out_data/out_last - output link (arbiter driven)
//               out_ready                 - downstream accept
//               grant, busy               - arbiter status
// Modports    : master - environment side (drives flits and out_ready)
//               slave  - arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface noc_output_port_arbiter_if
    import noc_arb_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
);

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;

    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;

    logic [N-1:0]   grant;
    logic           busy;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, grant, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, grant, busy
    );

endinterface
`default_nettype wire

// File: rtl/noc_output_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating priority encoder. Returns the first
//               set request bit found searching upward from ptr, wrapping
//               from N-1 back to 0.
// Ports       : req     (in)  N   request vector
//               ptr     (in)  IW  highest-priority position
//               win_idx (out) IW  index of the winning request
//               any_req (out) 1   at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  wire [N-1:0]  req,
    input  wire [IW-1:0] ptr,
    output logic [IW-1:0] win_idx,
    output logic          any_req
);

    // One spare bit so ptr + offset can exceed N-1 before wrapping.
    logic [IW:0] w_pos;
    logic        w_found;

    always_comb begin
        win_idx = '0;
        any_req = |req;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, ptr} + (IW+1)'(k);
            if (w_pos >= (IW+1)'(N)) begin
                w_pos = w_pos - (IW+1)'(N);
            end
            if (!w_found && req[w_pos[IW-1:0]]) begin
                w_found = 1'b1;
                win_idx = w_pos[IW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : noc_output_port_arbiter
// Description : Packet-granular round-robin arbiter sharing one NoC router
//               output port among N input ports. A grant is locked from the
//               first flit until the flit marked last has been transferred,
//               so packets never interleave on the output link.
// Ports       : CLK          (in)  clock, rising edge
//               RESET        (in)  synchronous reset, active high
//               bus          (slave modport of noc_output_port_arbiter_if)
//               timeout_err  (out) sticky stall-timeout flag, only present
//                                  when ARB_TIMEOUT_EN is defined
// Options     : ARB_TIMEOUT_EN - adds a stall counter that force-releases a
//                                lock after TIMEOUT cycles without a transfer
// Revision    : 1.0 - initial release
// ============================================================================
module noc_output_port_arbiter
    import noc_arb_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = 16
) (
    input  wire                       CLK,
    input  wire                       RESET,
    noc_output_port_arbiter_if.slave  bus
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                      timeout_err
`endif
);

    localparam int IW = $clog2(N);

    if ((N < 2) || (N > 8) || (TIMEOUT < 1)) begin : g_param_check
        $error("noc_output_port_arbiter: N must be 2..8 and TIMEOUT >= 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  w_grant_nxt;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] w_rr_ptr_nxt;
    logic          r_busy;
    logic          w_busy_nxt;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic [IW-1:0] w_win_idx;
    logic          w_any_req;
    logic [IW-1:0] w_gidx;
    logic [IW-1:0] w_gidx_inc;
    logic          w_xfer;
    logic          w_release;
    logic [W-1:0]  w_port_data [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign w_port_data[i] = bus.in_data[i*W +: W];
    end

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req     (bus.in_valid),
        .ptr     (r_rr_ptr),
        .win_idx (w_win_idx),
        .any_req (w_any_req)
    );

    // The grant register is the single source of truth for the locked port;
    // the index is recovered from it rather than stored separately.
    assign w_gidx     = IW'(onehot_to_idx(8'(r_grant)));
    assign w_gidx_inc = (w_gidx == IW'(N-1)) ? '0 : (w_gidx + 1'b1);

    // out_valid is only ever high while LOCKED, so this is a transfer of the
    // granted port's flit.
    assign w_xfer = bus.out_valid && bus.out_ready;

`ifdef ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT+1);

    logic [SW-1:0] r_stall;
    logic          w_timeout;

    assign w_timeout = (r_state == LOCKED) && !w_xfer && (r_stall == SW'(TIMEOUT));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stall     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((r_state != LOCKED) || w_xfer || w_timeout) begin
                r_stall <= '0;
            end else begin
                r_stall <= r_stall + 1'b1;
            end
            if (w_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign w_release = (w_xfer && bus.out_last) || w_timeout;
`else
    assign w_release = w_xfer && bus.out_last;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        w_busy_nxt   = r_busy;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = LOCKED;
                    w_grant_nxt = {{(N-1){1'b0}}, 1'b1} << w_win_idx;
                    w_busy_nxt  = 1'b1;
                end
            end
            LOCKED: begin
                // Moving the pointer past the released port makes it the
                // lowest-priority requester in the next arbitration.
                if (w_release) begin
                    w_state_nxt  = IDLE;
                    w_grant_nxt  = '0;
                    w_busy_nxt   = 1'b0;
                    w_rr_ptr_nxt = w_gidx_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (combinational from the registered grant)
    // ------------------------------------------------------------------
    always_comb begin
        bus.in_ready  = '0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        if (r_state == LOCKED) begin
            bus.in_ready  = r_grant & {N{bus.out_ready}};
            bus.out_valid = bus.in_valid[w_gidx];
            bus.out_data  = w_port_data[w_gidx];
            bus.out_last  = bus.in_last[w_gidx];
        end
    end

    assign bus.grant = r_grant;
    assign bus.busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_noc_output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_output_port_arbiter
// Description : Self-checking bench for noc_output_port_arbiter (N=4, W=8).
//               Directed per-cycle vectors with hand-computed outputs, plus
//               hand-written sequences for reset release, mid-packet reset
//               and (when ARB_TIMEOUT_EN is defined) stall timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_output_port_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    noc_output_port_arbiter_if #(.N(N), .W(W)) bus ();

`ifdef ARB_TIMEOUT_EN
    logic timeout_err;
`endif

    noc_output_port_arbiter #(
        .N       (N),
        .W       (W),
        .TIMEOUT (16)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    typedef struct {
        logic [3:0]  iv;
        logic [3:0]  il;
        logic        rdy;
        logic [31:0] d;
        logic [3:0]  gnt;
        logic        bsy;
        logic        ov;
        logic [7:0]  od;
        logic        ol;
        logic [3:0]  ir;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(logic [3:0] iv, logic [3:0] il, logic rdy, logic [31:0] d,
                                logic [3:0] gnt, logic bsy, logic ov, logic [7:0] od,
                                logic ol, logic [3:0] ir);
        vec_t v;
        v.iv = iv; v.il = il; v.rdy = rdy; v.d = d;
        v.gnt = gnt; v.bsy = bsy; v.ov = ov; v.od = od; v.ol = ol; v.ir = ir;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] iv, input logic [3:0] il, input logic rdy,
                         input logic [31:0] d);
        bus.in_valid  = iv;
        bus.in_last   = il;
        bus.out_ready = rdy;
        bus.in_data   = d;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] gnt, input logic bsy,
                           input logic ov, input logic [7:0] od, input logic ol,
                           input logic [3:0] ir);
        chk({tag, ".grant"},     32'(bus.grant),     32'(gnt));
        chk({tag, ".busy"},      32'(bus.busy),      32'(bsy));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, ".out_data"},  32'(bus.out_data),  32'(od));
        chk({tag, ".out_last"},  32'(bus.out_last),  32'(ol));
        chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(ir));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- per-cycle vectors (start right after reset) ----
        // Fairness: 3-flit packets on all ports, data = port*16 + flit.
        vq.push_back(mk(4'hF, 4'h0, 1, 32'h30201000, 4'h0, 0, 0, 8'h00, 0, 4'h0));
        vq.push_back(mk(4'hF, 4'h0, 1, 32'h30201000, 4'h1, 1, 1, 8'h00, 0, 4'h1));
        vq.push_back(mk(4'hF, 4'h0, 1, 32'h30201001, 4'h1, 1, 1, 8'h01, 0, 4'h1));
        vq.push_back(mk(4'hF, 4'h1, 1, 32'h30201002, 4'h1, 1, 1, 8'h02, 1, 4'h1));
        vq.push_back(mk(4'hF, 4'h0, 1, 32'h30201000, 4'h0, 0, 0, 8'h00, 0, 4'h0));
        vq.push_back(mk(4'hF, 4'h0, 1, 32'h30201000, 4'h2, 1, 1, 8'h10, 0, 4'h2));
        vq.push_back(mk(4'hF, 4'h0, 1, 32'h30201100, 4'h2, 1, 1, 8'h11, 0, 4'h2));
        vq.push_back(mk(4'hF, 4'h2, 1, 32'h30201200, 4'h2, 1, 1, 8'h12, 1, 4'h2));
        vq.push_back(mk(4'hF, 4'h0, 1, 32'h30201000, 4'h0, 0, 0, 8'h00, 0, 4'h0));
        vq.push_back(mk(4'hF, 4'h0, 1, 32'h30201000, 4'h4, 1, 1, 8'h20, 0, 4'h4));
        vq.push_back(mk(4'hF, 4'h0, 1, 32'h30211000, 4'h4, 1, 1, 8'h21, 0, 4'h4));
        vq.push_back(mk(4'hF, 4'h4, 1, 32'h30221000, 4'h4, 1, 1, 8'h22, 1, 4'h4));
        vq.push_back(mk(4'hF, 4'h0, 1, 32'h30201000, 4'h0, 0, 0, 8'h00, 0, 4'h0));
        vq.push_back(mk(4'hF, 4'h0, 1, 32'h30201000, 4'h8, 1, 1, 8'h30, 0, 4'h8));
        vq.push_back(mk(4'hF, 4'h0, 1, 32'h31201000, 4'h8, 1, 1, 8'h31, 0, 4'h8));
        vq.push_back(mk(4'hF, 4'h8, 1, 32'h32201000, 4'h8, 1, 1, 8'h32, 1, 4'h8));
        vq.push_back(mk(4'hF, 4'h0, 1, 32'h30201000, 4'h0, 0, 0, 8'h00, 0, 4'h0));
        vq.push_back(mk(4'hF, 4'h0, 1, 32'h30201000, 4'h1, 1, 1, 8'h00, 0, 4'h1));
        // Backpressure: out_ready low for 5 cycles on flit 1 of port 0.
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(4'hF, 4'h0, 0, 32'h302010A5, 4'h1, 1, 1, 8'hA5, 0, 4'h0));
        vq.push_back(mk(4'hF, 4'h0, 1, 32'h302010A5, 4'h1, 1, 1, 8'hA5, 0, 4'h1));
        vq.push_back(mk(4'hF, 4'h1, 1, 32'h30201002, 4'h1, 1, 1, 8'h02, 1, 4'h1));
        // Rotation wrap: lone port 3 single flit, then ports 0 and 3 together.
        vq.push_back(mk(4'h8, 4'h0, 1, 32'h33000000, 4'h0, 0, 0, 8'h00, 0, 4'h0));
        vq.push_back(mk(4'h8, 4'h8, 1, 32'h33000000, 4'h8, 1, 1, 8'h33, 1, 4'h8));
        vq.push_back(mk(4'h9, 4'h0, 1, 32'h33000044, 4'h0, 0, 0, 8'h00, 0, 4'h0));
        vq.push_back(mk(4'h9, 4'h1, 1, 32'h33000044, 4'h1, 1, 1, 8'h44, 1, 4'h1));
        // Granted source drops valid mid-packet: lock is kept.
        vq.push_back(mk(4'h2, 4'h0, 1, 32'h00005500, 4'h0, 0, 0, 8'h00, 0, 4'h0));
        vq.push_back(mk(4'h2, 4'h0, 1, 32'h00005500, 4'h2, 1, 1, 8'h55, 0, 4'h2));
        vq.push_back(mk(4'h0, 4'h0, 1, 32'h00005600, 4'h2, 1, 0, 8'h56, 0, 4'h2));
        vq.push_back(mk(4'h2, 4'h2, 1, 32'h00005700, 4'h2, 1, 1, 8'h57, 1, 4'h2));
        vq.push_back(mk(4'h0, 4'h0, 1, 32'h00000000, 4'h0, 0, 0, 8'h00, 0, 4'h0));
        vq.push_back(mk(4'h0, 4'h0, 1, 32'h00000000, 4'h0, 0, 0, 8'h00, 0, 4'h0));

        // ---------------- reset with all ports requesting ----------------
        rst = 1'b1;
        drive(4'hF, 4'h0, 1'b1, 32'hA3A2A1A0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_out("in_reset", 4'h0, 0, 0, 8'h00, 0, 4'h0);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        chk_out("reset_release", 4'h1, 1, 1, 8'hA0, 0, 4'h1);

        // Clean restart for the vector table.
        @(negedge clk);
        rst = 1'b1;
        drive(4'h0, 4'h0, 1'b1, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i].iv, vq[i].il, vq[i].rdy, vq[i].d);
            #1;
            chk_out($sformatf("vec%0d", i), vq[i].gnt, vq[i].bsy, vq[i].ov,
                    vq[i].od, vq[i].ol, vq[i].ir);
            @(negedge clk);
        end

        // ---------------- reset mid-packet (rr_ptr is 2 here) -----------
        drive(4'h4, 4'h0, 1'b1, 32'h00770000);
        @(negedge clk); #1;
        chk_out("mid_flit1", 4'h4, 1, 1, 8'h77, 0, 4'h4);
        @(negedge clk);
        drive(4'h4, 4'h0, 1'b1, 32'h00780000);
        #1;
        chk_out("mid_flit2", 4'h4, 1, 1, 8'h78, 0, 4'h4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk_out("mid_reset", 4'h0, 0, 0, 8'h00, 0, 4'h0);
        rst = 1'b0;
        drive(4'hA, 4'h0, 1'b1, 32'h33221100);
        @(negedge clk); #1;
        // Pointer back at 0 picks port 1; a surviving pointer of 2 would pick port 3.
        chk_out("post_reset_arb", 4'h2, 1, 1, 8'h11, 0, 4'h2);

`ifdef ARB_TIMEOUT_EN
        // ---------------- stall timeout -----------------------------------
        @(negedge clk);
        rst = 1'b1;
        drive(4'h0, 4'h0, 1'b1, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'h3, 4'h0, 1'b1, 32'h0000BB01);
        @(negedge clk); #1;
        chk("to_grant0", 32'(bus.grant), 32'h1);
        chk("to_err_clear", 32'(timeout_err), 32'h0);
        @(negedge clk);
        drive(4'h2, 4'h0, 1'b1, 32'h0000BB01);
        begin
            int cyc;
            cyc = 0;
            while ((bus.grant != 4'h2) && (cyc < 40)) begin
                @(negedge clk);
                cyc++;
            end
            #1;
            chk("to_within_bound", 32'(cyc < 40), 32'h1);
            chk("to_min_wait", 32'(cyc >= 16), 32'h1);
            chk("to_err_set", 32'(timeout_err), 32'h1);
            chk("to_next_grant", 32'(bus.grant), 32'h2);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
